mem_responder: RTL and testbench

Memory-side responder for the Mini SRC datapath: answers the `Read`/`Write` strobes issued by the control unit, using the MAR address and the MDR write data, and returns read data for loading into the MDR. The block holds a single-port synchronous RAM behind a four-phase level handshake with programmable wait states. This lets control-unit states such as `ld`/`st` and the fetch states stall until memory reports `Done`.

---
 rtl/mem_pkg.sv | 17 +
 rtl/mem_array.sv | 38 +++
 rtl/mem_responder.sv | 105 ++++++++++
 tb/tb_mem_responder.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared memory-interface package: responder FSM states and the default
// address/data geometry reused by the datapath MAR/MDR.
package mem_pkg;

  localparam int MEM_ADDR_WIDTH = 9;
  localparam int MEM_DATA_WIDTH = 32;
  localparam int MEM_DEPTH      = 512;
  localparam int MEM_CNT_W      = 4;   // wait counter covers 0..15

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    ACCESS = 2'd2,
    DONE   = 2'd3
  } mem_state_t;

endpackage

// File: rtl/mem_array.sv
// Single-port synchronous RAM: write enable, registered read with a
// synchronous clear on the output register so it maps onto block RAM.
module mem_array
  import mem_pkg::*;
#(
  parameter int    ADDR_WIDTH = MEM_ADDR_WIDTH,
  parameter int    DATA_WIDTH = MEM_DATA_WIDTH,
  parameter int    DEPTH      = MEM_DEPTH,
  parameter string INIT_FILE  = ""
) (
  input  logic                  clk,
  input  logic                  clr,
  input  logic                  we,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];
  logic [IDX_W-1:0]      idx;

  assign idx = addr[IDX_W-1:0];

  // Array write port; the array itself carries no reset
  always_ff @(posedge clk) begin
    if (we) mem[idx] <= wdata;
  end

  // Registered read; clr forces the output register to zero
  always_ff @(posedge clk) begin
    if (clr)     rdata <= '0;
    else if (re) rdata <= mem[idx];
  end

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: four-phase Read/Write level handshake with
// WAIT_CYCLES wait states in front of a one-cycle RAM access.
// Optional feature macro: MEM_BOUNDS_CHECK_EN adds the Err port and an
// address >= DEPTH check that suppresses writes and reads back zero.
module mem_responder
  import mem_pkg::*;
#(
  parameter int    ADDR_WIDTH  = MEM_ADDR_WIDTH,
  parameter int    DATA_WIDTH  = MEM_DATA_WIDTH,
  parameter int    DEPTH       = MEM_DEPTH,
  parameter int    WAIT_CYCLES = 1,
  parameter string INIT_FILE   = ""
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  Read,
  input  logic                  Write,
  input  logic [ADDR_WIDTH-1:0] Addr,
  input  logic [DATA_WIDTH-1:0] WData,
  output logic [DATA_WIDTH-1:0] RData,
  output logic                  Done,
  output logic                  Busy
`ifdef MEM_BOUNDS_CHECK_EN
  ,
  output logic                  Err
`endif
);

  mem_state_t            state;
  logic [MEM_CNT_W-1:0]  cnt;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic                  op_wr;
  logic                  oob;
  logic                  in_access;
  logic                  arr_we;
  logic                  arr_re;
  logic                  arr_clr;

`ifdef MEM_BOUNDS_CHECK_EN
  assign oob = ({1'b0, addr_q} >= (ADDR_WIDTH + 1)'(DEPTH));
  assign Err = (state == DONE) && oob;
`else
  assign oob = 1'b0;
`endif

  assign Done = (state == DONE);
  assign Busy = (state != IDLE);

  // Reset overrides the access cycle: no array write, output register cleared
  assign in_access = (state == ACCESS) && !Reset;
  assign arr_we    = in_access &&  op_wr && !oob;
  assign arr_re    = in_access && !op_wr && !oob;
  assign arr_clr   = Reset || (in_access && !op_wr && oob);

  // Handshake FSM with wait counter and request latches
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state <= IDLE;
      cnt   <= '0;
      op_wr <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (Read || Write) begin
            addr_q  <= Addr;
            wdata_q <= WData;
            op_wr   <= Write;   // write wins when both requests are high
            if (WAIT_CYCLES > 0) begin
              state <= WAIT;
              cnt   <= MEM_CNT_W'(WAIT_CYCLES);
            end else begin
              state <= ACCESS;
            end
          end
        end
        WAIT: begin
          cnt <= cnt - 1'b1;
          if (cnt == MEM_CNT_W'(1)) state <= ACCESS;
        end
        ACCESS: state <= DONE;
        DONE: begin
          if (!Read && !Write) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  mem_array #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .INIT_FILE  (INIT_FILE)
  ) u_array (
    .clk   (Clock),
    .clr   (arr_clr),
    .we    (arr_we),
    .re    (arr_re),
    .addr  (addr_q),
    .wdata (wdata_q),
    .rdata (RData)
  );

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: one instance with one wait state and
// one with zero wait states; bounds-check vectors when MEM_BOUNDS_CHECK_EN
// is defined.
module tb_mem_responder;

`ifdef MEM_BOUNDS_CHECK_EN
  localparam int DEPTH_A = 256;
`else
  localparam int DEPTH_A = 512;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        read_a, write_a, read_b, write_b;
  logic [8:0]  addr_a, addr_b;
  logic [31:0] wdata_a, wdata_b;
  logic [31:0] rdata_a, rdata_b;
  logic        done_a, busy_a, done_b, busy_b;
`ifdef MEM_BOUNDS_CHECK_EN
  logic        err_a, err_b;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mem_responder #(
    .ADDR_WIDTH (9), .DATA_WIDTH (32), .DEPTH (DEPTH_A), .WAIT_CYCLES (1)
  ) dut_a (
    .Clock (clk), .Reset (rst), .Read (read_a), .Write (write_a),
    .Addr (addr_a), .WData (wdata_a), .RData (rdata_a),
    .Done (done_a), .Busy (busy_a)
`ifdef MEM_BOUNDS_CHECK_EN
    , .Err (err_a)
`endif
  );

  mem_responder #(
    .ADDR_WIDTH (9), .DATA_WIDTH (32), .DEPTH (DEPTH_A), .WAIT_CYCLES (0)
  ) dut_b (
    .Clock (clk), .Reset (rst), .Read (read_b), .Write (write_b),
    .Addr (addr_b), .WData (wdata_b), .RData (rdata_b),
    .Done (done_b), .Busy (busy_b)
`ifdef MEM_BOUNDS_CHECK_EN
    , .Err (err_b)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input int which, input logic rd, input logic wr,
                        input logic [8:0] a, input logic [31:0] d);
    if (which == 0) begin
      read_a = rd; write_a = wr; addr_a = a; wdata_a = d;
    end else begin
      read_b = rd; write_b = wr; addr_b = a; wdata_b = d;
    end
  endtask

  function automatic logic done_of(input int which);
    return (which == 0) ? done_a : done_b;
  endfunction

  function automatic logic busy_of(input int which);
    return (which == 0) ? busy_a : busy_b;
  endfunction

  // Raise a request, scramble Addr/WData after the sampling edge, and
  // count edges until Done (bounded). Requests are left asserted.
  task automatic req(input int which, input logic rd, input logic wr,
                     input logic [8:0] a, input logic [31:0] d,
                     input int exp_lat, input string tag);
    int n;
    n = 0;
    set_in(which, rd, wr, a, d);
    do begin
      tick();
      n++;
      if (n == 1) begin
        set_in(which, rd, wr, ~a, ~d);
        check({tag, ".busy"}, 32'(busy_of(which)), 32'd1);
      end
    end while (!done_of(which) && n < 20);
    check({tag, ".lat"}, n, exp_lat);
  endtask

  // Drop both requests and confirm the return to IDLE one edge later
  task automatic release_req(input int which, input string tag);
    set_in(which, 1'b0, 1'b0, 9'h000, 32'h0);
    tick();
    check({tag, ".idle"}, {30'd0, busy_of(which), done_of(which)}, 32'd0);
  endtask

  initial begin
    int done_cnt;
    rst = 1'b1;
    set_in(0, 1'b0, 1'b0, 9'h000, 32'h0);
    set_in(1, 1'b0, 1'b0, 9'h000, 32'h0);
    tick();
    tick();
    check("reset.rdata", rdata_a, 32'h0);
    check("reset.flags", {30'd0, busy_a, done_a}, 32'd0);
    rst = 1'b0;
    tick();

    // Basic write then read, one wait state
    req(0, 1'b0, 1'b1, 9'h055, 32'hDEADBEEF, 3, "wr055");
    check("wr055.rdata", rdata_a, 32'h0);
    release_req(0, "wr055");
    req(0, 1'b1, 1'b0, 9'h055, 32'h0, 3, "rd055");
    check("rd055.rdata", rdata_a, 32'hDEADBEEF);
    release_req(0, "rd055");

    // Held read: one access, Done stays high for the whole hold
    req(0, 1'b1, 1'b0, 9'h055, 32'h0, 3, "held");
    done_cnt = 0;
    for (int i = 0; i < 7; i++) begin
      tick();
      if (done_a) done_cnt++;
    end
    check("held.done_cycles", done_cnt, 7);
    check("held.rdata", rdata_a, 32'hDEADBEEF);
    release_req(0, "held");

    // Simultaneous requests resolve as a write
    req(0, 1'b1, 1'b1, 9'h010, 32'h12345678, 3, "both");
    check("both.rdata_kept", rdata_a, 32'hDEADBEEF);
    release_req(0, "both");
    req(0, 1'b1, 1'b0, 9'h010, 32'h0, 3, "rd010");
    check("rd010.rdata", rdata_a, 32'h12345678);
    release_req(0, "rd010");

`ifndef MEM_BOUNDS_CHECK_EN
    // Top address of a full-depth array
    req(0, 1'b0, 1'b1, 9'h1FF, 32'h80000001, 3, "wr1ff");
    release_req(0, "wr1ff");
    req(0, 1'b1, 1'b0, 9'h1FF, 32'h0, 3, "rd1ff");
    check("rd1ff.rdata", rdata_a, 32'h80000001);
    release_req(0, "rd1ff");
`endif

    // Reset during WAIT discards the latched write
    req(0, 1'b0, 1'b1, 9'h020, 32'hA5A5A5A5, 3, "wr020");
    release_req(0, "wr020");
    set_in(0, 1'b0, 1'b1, 9'h020, 32'hFFFFFFFF);
    tick();
    rst = 1'b1;
    set_in(0, 1'b0, 1'b0, 9'h000, 32'h0);
    tick();
    rst = 1'b0;
    check("rstwait.flags", {30'd0, busy_a, done_a}, 32'd0);
    check("rstwait.rdata", rdata_a, 32'h0);
    req(0, 1'b1, 1'b0, 9'h020, 32'h0, 3, "rd020a");
    check("rd020a.rdata", rdata_a, 32'hA5A5A5A5);
    release_req(0, "rd020a");

    // Reset coinciding with ACCESS wins over the array write
    set_in(0, 1'b0, 1'b1, 9'h020, 32'hFFFFFFFF);
    tick();
    tick();
    rst = 1'b1;
    set_in(0, 1'b0, 1'b0, 9'h000, 32'h0);
    tick();
    rst = 1'b0;
    check("rstacc.flags", {30'd0, busy_a, done_a}, 32'd0);
    req(0, 1'b1, 1'b0, 9'h020, 32'h0, 3, "rd020b");
    check("rd020b.rdata", rdata_a, 32'hA5A5A5A5);
    release_req(0, "rd020b");

`ifdef MEM_BOUNDS_CHECK_EN
    // Out-of-range read returns zero with Err during DONE
    req(0, 1'b0, 1'b1, 9'h0F0, 32'h00001111, 3, "wr0f0");
    check("wr0f0.err", 32'(err_a), 32'd0);
    release_req(0, "wr0f0");
    req(0, 1'b1, 1'b0, 9'h055, 32'h0, 3, "rd055b");
    release_req(0, "rd055b");
    req(0, 1'b1, 1'b0, 9'h1F0, 32'h0, 3, "rd1f0");
    check("rd1f0.rdata", rdata_a, 32'h0);
    check("rd1f0.err", 32'(err_a), 32'd1);
    release_req(0, "rd1f0");
    check("rd1f0.err_clear", 32'(err_a), 32'd0);
    req(0, 1'b0, 1'b1, 9'h1F0, 32'h00000BAD, 3, "wr1f0");
    check("wr1f0.err", 32'(err_a), 32'd1);
    release_req(0, "wr1f0");
    req(0, 1'b1, 1'b0, 9'h0F0, 32'h0, 3, "rd0f0");
    check("rd0f0.rdata", rdata_a, 32'h00001111);
    check("rd0f0.err", 32'(err_a), 32'd0);
    release_req(0, "rd0f0");
    req(0, 1'b1, 1'b0, 9'h055, 32'h0, 3, "rd055c");
    check("rd055c.rdata", rdata_a, 32'hDEADBEEF);
    release_req(0, "rd055c");
`endif

    // Zero wait states: Done after two edges
    req(1, 1'b0, 1'b1, 9'h000, 32'h00000001, 2, "b.wr000");
    release_req(1, "b.wr000");
    req(1, 1'b1, 1'b0, 9'h000, 32'h0, 2, "b.rd000");
    check("b.rd000.rdata", rdata_b, 32'h00000001);
    release_req(1, "b.rd000");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Absolute time bound so the run always ends
  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded its time budget");
    $fatal(1, "timeout");
  end

endmodule
